sdr_write_packer: RTL and testbench
===================================

SDR_WRITE_PACKER -- requirements
Module: sdr_write_packer

Interface
REQ-001 SHALL have parameter NWORDS, default 64, meaning the number of 32-bit slots per burst (NWORDS*32 = 2048).
REQ-002 SHALL have port sdr_clk  in  1  the only clock; all logic is on its rising edge.
REQ-003 SHALL have port sdr_reset_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  in  1  one-cycle pulse that loads base_addr and begins a session.
REQ-005 SHALL have port base_addr  in  32  byte address of the first word in the session.
REQ-006 SHALL have port in_valid  in  1  producer word valid.
REQ-007 SHALL have port in_data  in  32  producer word.
REQ-008 SHALL have port in_ready  out  1  packer accepts a word this cycle.
REQ-009 SHALL have port flush  in  1  one-cycle pulse that ends the session after the current partial burst.
REQ-010 SHALL have port sdr_writedata  out  2048  burst payload, word k at bits [32k +: 32].
REQ-011 SHALL have port sdr_baseaddr  out  32  byte address of the current burst.
REQ-012 SHALL have port sdr_nelems  out  30  valid 32-bit words in the current burst.
REQ-013 SHALL have port sdr_writestart  out  1  one-cycle burst request.
REQ-014 SHALL have port sdr_writeend  in  1  burst-complete pulse from the SDRAM bridge.
REQ-015 SHALL have port busy  out  1  session active (any state other than IDLE).
REQ-016 SHALL have port done  out  1  one-cycle pulse when a flushed session completes.

Function
REQ-017 SHALL implement the states IDLE, FILL, ISSUE and WAIT.
REQ-018 IDLE: start=1 SHALL latch base_addr into sdr_baseaddr, clear the slot count, and go to FILL; all other inputs SHALL be ignored in IDLE.
REQ-019 FILL: in_ready SHALL be 1; on in_valid&&in_ready, in_data SHALL be written to slot count and count SHALL increment.
REQ-020 FILL: accepting the word that makes count reach NWORDS SHALL move the block to ISSUE on the next cycle.
REQ-021 FILL: when flush=1 and in_valid=1 in the same cycle, the word SHALL be accepted first and the flush SHALL be applied to count+1.
REQ-022 FILL: flush with a resulting count>0 SHALL set flush_pending and go to ISSUE.
REQ-023 FILL: flush with count=0 SHALL pulse done and go to IDLE without issuing a burst.
REQ-024 ISSUE: sdr_writestart SHALL be 1 for exactly one cycle, sdr_nelems SHALL equal count, and the state SHALL go to WAIT; in_ready SHALL be 0.
REQ-025 Latency: when the NWORDS-th word is accepted in cycle N, sdr_writestart SHALL assert in cycle N+1.
REQ-026 WAIT: in_ready SHALL be 0, and sdr_writedata, sdr_baseaddr and sdr_nelems SHALL be held stable until sdr_writeend.
REQ-027 sdr_writeend SHALL be sampled only in WAIT and ignored in every other state.
REQ-028 On sdr_writeend in WAIT, sdr_baseaddr SHALL increase by 4*sdr_nelems (modulo 2^32, wrap allowed) and count SHALL clear.
REQ-029 On sdr_writeend, the block SHALL then go to IDLE with a one-cycle done pulse if flush_pending is set, and to FILL otherwise.
REQ-030 A start pulse outside IDLE SHALL be ignored; a flush pulse outside FILL SHALL be ignored.
REQ-031 Slots at index >= sdr_nelems SHALL hold the fill value defined in REQ-036/REQ-037.

Reset
REQ-032 When sdr_reset_n=0 at a clock edge, the block SHALL go to IDLE with count=0, flush_pending=0, and outputs sdr_writestart=0, in_ready=0, busy=0, done=0, sdr_nelems=0, sdr_baseaddr=0 and sdr_writedata all zero.
REQ-033 Reset mid-burst (during ISSUE or WAIT) SHALL abandon the burst, and a later sdr_writeend SHALL be ignored.

Configuration
REQ-034 The block SHALL have exactly one compile-time feature, controlled by the macro SDR_WRITE_PAD_EN.
REQ-035 The feature SHALL only change the fill value of unused slots.
REQ-036 With SDR_WRITE_PAD_EN defined, unused slots SHALL be refilled with 32'hDEADBEEF on entry to FILL, after reset and after each burst.
REQ-037 Without SDR_WRITE_PAD_EN, unused slots SHALL be refilled with 32'h0 at the same points.

Verification
REQ-038 Scenario 1: start with base_addr=0x1000, then 64 consecutive words 0..63 -> sdr_writestart one cycle after word 63, nelems=64, slot k=k, baseaddr=0x1000; after writeend, baseaddr=0x1100 and the block is in FILL.
REQ-039 Scenario 2: 5 words 0xA0..0xA4, then flush -> one burst with nelems=5, slots 5..63 = 0xDEADBEEF (SDR_WRITE_PAD_EN defined) or 0 (undefined); done pulses one cycle after writeend.
REQ-040 Scenario 3: flush in the same cycle as the 3rd word (in_valid=1) -> nelems=3 and the 3rd word is present in slot 2.
REQ-041 Scenario 4: start followed immediately by flush with no words -> done pulses, no sdr_writestart, the block returns to IDLE.
REQ-042 Scenario 5: sdr_reset_n low for 1 cycle during WAIT, then sdr_writeend pulsed -> all outputs at reset values, no done, the block stays in IDLE.
REQ-043 Scenario 6: in_valid held high through WAIT with writeend delayed 10 cycles -> in_ready=0 throughout and no words lost or duplicated; base_addr=0xFFFFFF00 with a full burst wraps sdr_baseaddr to 0x00000000.

Source files
------------

// File: rtl/sdr_write_packer_if.sv
// ---------------------------------------------------------------------------
// sdr_write_packer_if
//   Signal bundle between the write packer, its word producer and the SDRAM
//   write bridge.
//
//   master : environment side (producer + bridge), drives start/base_addr,
//            in_valid/in_data, flush and sdr_writeend.
//   slave  : packer side, drives in_ready, the burst outputs, busy and done.
//
//   Producer : start, base_addr, in_valid, in_data, in_ready, flush
//   Bridge   : sdr_writedata, sdr_baseaddr, sdr_nelems, sdr_writestart,
//              sdr_writeend
//   Status   : busy, done
// ---------------------------------------------------------------------------
interface sdr_write_packer_if #(
    parameter int NWORDS = 64
);
    logic                   start;
    logic [31:0]            base_addr;
    logic                   in_valid;
    logic [31:0]            in_data;
    logic                   in_ready;
    logic                   flush;
    logic [NWORDS*32-1:0]   sdr_writedata;
    logic [31:0]            sdr_baseaddr;
    logic [29:0]            sdr_nelems;
    logic                   sdr_writestart;
    logic                   sdr_writeend;
    logic                   busy;
    logic                   done;

    modport master (
        output start, base_addr, in_valid, in_data, flush, sdr_writeend,
        input  in_ready, sdr_writedata, sdr_baseaddr, sdr_nelems,
               sdr_writestart, busy, done
    );

    modport slave (
        input  start, base_addr, in_valid, in_data, flush, sdr_writeend,
        output in_ready, sdr_writedata, sdr_baseaddr, sdr_nelems,
               sdr_writestart, busy, done
    );
endinterface

// File: rtl/sdr_write_packer.sv
// ---------------------------------------------------------------------------
// sdr_write_packer
//   Packs a stream of 32-bit words into NWORDS-slot bursts for an SDRAM write
//   bridge. A session opens with start (latching base_addr), collects words,
//   issues a burst every NWORDS words and, on flush, issues the remaining
//   partial burst before closing with a done pulse. The burst address
//   advances by 4 bytes per word after each completed burst (wraps mod 2^32).
//
//   Ports
//     sdr_clk      : single clock, rising edge
//     sdr_reset_n  : synchronous active-low reset
//     bus          : sdr_write_packer_if.slave (producer, bridge, status)
//
//   Compile-time option
//     SDR_WRITE_PAD_EN : unused burst slots read 32'hDEADBEEF instead of 0.
// ---------------------------------------------------------------------------
module sdr_write_packer #(
    parameter int NWORDS = 64
) (
    input  logic                sdr_clk,
    input  logic                sdr_reset_n,
    sdr_write_packer_if.slave   bus
);

`ifdef SDR_WRITE_PAD_EN
    localparam logic [31:0] FILL_WORD = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] FILL_WORD = 32'h0000_0000;
`endif
    localparam logic [NWORDS*32-1:0] FILL_VEC   = {NWORDS{FILL_WORD}};
    localparam logic [29:0]          FULL_COUNT = 30'(NWORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [29:0]            count_r;
    logic [29:0]            count_inc_s;
    logic                   flush_pending_r;
    logic [NWORDS*32-1:0]   data_r;
    logic [31:0]            base_r;
    logic                   accept_s;

    logic                   in_ready_r;
    logic                   busy_r;
    logic                   writestart_r;
    logic                   done_r;
    logic                   in_ready_s;
    logic                   busy_s;
    logic                   writestart_s;
    logic                   done_s;

    // State register.
    always_ff @(posedge sdr_clk) begin
        if (!sdr_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode plus the word-accept strobe it depends on.
    always_comb begin
        accept_s    = in_ready_r && bus.in_valid;
        count_inc_s = count_r + 30'd1;
        state_s     = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (bus.flush) begin
                    // A word accepted in the flush cycle belongs to the final burst.
                    if (accept_s || (count_r != 30'd0)) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (accept_s && (count_inc_s == FULL_COUNT)) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.sdr_writeend) begin
                    if (flush_pending_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the flops present it in that state.
    always_comb begin
        in_ready_s   = (state_s == ST_FILL);
        busy_s       = (state_s != ST_IDLE);
        writestart_s = (state_s == ST_ISSUE);
        // A session ends either by an empty flush in FILL or after its last burst.
        if ((state_s == ST_IDLE) && ((state_r == ST_FILL) || (state_r == ST_WAIT))) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // Registered control outputs.
    always_ff @(posedge sdr_clk) begin
        if (!sdr_reset_n) begin
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            writestart_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            in_ready_r   <= in_ready_s;
            busy_r       <= busy_s;
            writestart_r <= writestart_s;
            done_r       <= done_s;
        end
    end

    // Burst datapath: slot storage, word count, burst address, flush flag.
    always_ff @(posedge sdr_clk) begin
        if (!sdr_reset_n) begin
            count_r         <= 30'd0;
            flush_pending_r <= 1'b0;
            data_r          <= '0;
            base_r          <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        base_r          <= bus.base_addr;
                        count_r         <= 30'd0;
                        flush_pending_r <= 1'b0;
                        data_r          <= FILL_VEC;
                    end
                end
                ST_FILL: begin
                    if (accept_s) begin
                        for (int k = 0; k < NWORDS; k++) begin
                            if (count_r == 30'(k)) begin
                                data_r[k*32 +: 32] <= bus.in_data;
                            end
                        end
                        count_r <= count_inc_s;
                    end
                    if (bus.flush && (state_s == ST_ISSUE)) begin
                        flush_pending_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.sdr_writeend) begin
                        // count_r is the burst's word count, so this adds 4 bytes per word.
                        base_r          <= base_r + {count_r, 2'b00};
                        count_r         <= 30'd0;
                        flush_pending_r <= 1'b0;
                        data_r          <= FILL_VEC;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready_r;
    assign bus.busy           = busy_r;
    assign bus.sdr_writestart = writestart_r;
    assign bus.done           = done_r;
    // sdr_nelems mirrors the live count: held through ISSUE/WAIT, 0 after a burst.
    assign bus.sdr_nelems     = count_r;
    assign bus.sdr_baseaddr   = base_r;
    assign bus.sdr_writedata  = data_r;

endmodule

// File: tb/tb_sdr_write_packer.sv
// ---------------------------------------------------------------------------
// tb_sdr_write_packer
//   Scoreboard bench for sdr_write_packer. Each session's expected bursts are
//   computed up front from the word list (chunks of NWORDS, addresses
//   advancing by 4 bytes per word) and queued; a monitor pops and compares on
//   every sdr_writestart, checks hold/in_ready during the burst and checks
//   the done pulses. A bridge process answers each burst with sdr_writeend.
// ---------------------------------------------------------------------------
module tb_sdr_write_packer;
    localparam int NWORDS = 64;
`ifdef SDR_WRITE_PAD_EN
    localparam logic [31:0] PAD = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] PAD = 32'h0000_0000;
`endif

    typedef struct {
        logic [31:0]          addr;
        int                   n;
        logic [NWORDS*32-1:0] data;
        bit                   last;
    } burst_t;

    logic   sdr_clk = 1'b0;
    logic   sdr_reset_n;
    int     vectors = 0;
    int     errors = 0;
    burst_t exp_q[$];
    int     imm_done_cnt = 0;
    bit     mon_open = 1'b0;
    int     bridge_delay = 0;

    sdr_write_packer_if #(.NWORDS(NWORDS)) bus ();

    sdr_write_packer #(.NWORDS(NWORDS)) dut (
        .sdr_clk     (sdr_clk),
        .sdr_reset_n (sdr_reset_n),
        .bus         (bus)
    );

    always #5 sdr_clk = ~sdr_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [NWORDS*32-1:0] got,
                            input logic [NWORDS*32-1:0] exp);
        int first;
        vectors++;
        if (got !== exp) begin
            errors++;
            first = -1;
            for (int k = NWORDS - 1; k >= 0; k--) begin
                if (got[k*32 +: 32] !== exp[k*32 +: 32]) first = k;
            end
            $display("FAIL %s: slot %0d got 0x%08h, expected 0x%08h (t=%0t)", name, first,
                     got[first*32 +: 32], exp[first*32 +: 32], $time);
        end
    endtask

    task automatic timeout_fail(input string what);
        vectors++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", what, $time);
    endtask

    task automatic tick();
        @(posedge sdr_clk);
        #1;
    endtask

    // Reference model: split the session's words into bursts of NWORDS.
    task automatic model_session(input logic [31:0] base, input logic [31:0] words[$],
                                 input bit flush_with_last);
        int total = words.size();
        int nb    = (total + NWORDS - 1) / NWORDS;
        bit ends_in_burst = (total > 0) && (((total % NWORDS) != 0) || flush_with_last);
        for (int b = 0; b < nb; b++) begin
            burst_t e;
            e.addr = base + 32'(4 * NWORDS * b);
            e.n    = (total - b * NWORDS < NWORDS) ? (total - b * NWORDS) : NWORDS;
            e.data = {NWORDS{PAD}};
            for (int j = 0; j < e.n; j++) e.data[j*32 +: 32] = words[b * NWORDS + j];
            e.last = ends_in_burst && (b == nb - 1);
            exp_q.push_back(e);
        end
        if (!ends_in_burst) imm_done_cnt++;
    endtask

    task automatic wait_ready(input string who);
        int t = 0;
        @(negedge sdr_clk);
        while ((bus.in_ready !== 1'b1) && (t < 2000)) begin
            @(negedge sdr_clk);
            t++;
        end
        if (t >= 2000) timeout_fail(who);
    endtask

    task automatic wait_writeend();
        int t = 0;
        @(negedge sdr_clk);
        while ((bus.sdr_writeend !== 1'b1) && (t < 2000)) begin
            @(negedge sdr_clk);
            t++;
        end
        if (t >= 2000) timeout_fail("wait_writeend");
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge sdr_clk);
        while ((bus.busy !== 1'b0) && (t < 4000)) begin
            @(negedge sdr_clk);
            t++;
        end
        if (t >= 4000) timeout_fail("wait_idle");
        repeat (2) tick();
    endtask

    task automatic begin_session(input logic [31:0] base, input logic [31:0] words[$],
                                 input bit flush_with_last);
        model_session(base, words, flush_with_last);
        bus.start     = 1'b1;
        bus.base_addr = base;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic send_words(input logic [31:0] words[$], input bit flush_with_last,
                              input int max_gap, input bit noise);
        for (int i = 0; i < words.size(); i++) begin
            int g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (g > 0) begin
                bus.in_valid = 1'b0;
                repeat (g) tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = words[i];
            bus.flush    = flush_with_last && (i == words.size() - 1);
            if (noise) begin
                bus.start     = 1'($urandom_range(0, 1));
                bus.base_addr = $urandom;
            end
            wait_ready("send_word");
            tick();
            bus.flush = 1'b0;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_flush();
        wait_ready("flush");
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic end_session(input int total, input bit flush_with_last);
        if (!flush_with_last || (total == 0)) do_flush();
        wait_idle();
    endtask

    // Bridge: answers every burst request with a one-cycle sdr_writeend.
    initial begin : bridge
        int d;
        bus.sdr_writeend = 1'b0;
        forever begin
            @(negedge sdr_clk);
            if (bus.sdr_writestart === 1'b1) begin
                d = (bridge_delay > 0) ? bridge_delay : int'($urandom_range(1, 6));
                repeat (d) @(posedge sdr_clk);
                #1;
                bus.sdr_writeend = 1'b1;
                @(posedge sdr_clk);
                #1;
                bus.sdr_writeend = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each burst and checks hold and done.
    initial begin : monitor
        burst_t cur;
        bit     chk_done_next;
        bit     exp_done_next;
        chk_done_next = 1'b0;
        exp_done_next = 1'b0;
        forever begin
            @(negedge sdr_clk);
            if (chk_done_next) begin
                chk("done_after_writeend", 32'(bus.done), 32'(exp_done_next));
                chk_done_next = 1'b0;
            end else if (bus.done === 1'b1) begin
                vectors++;
                if (imm_done_cnt == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got 1, expected 0 (t=%0t)", $time);
                end else begin
                    imm_done_cnt--;
                end
            end
            if (mon_open) begin
                chk("in_ready_in_burst", 32'(bus.in_ready), 32'd0);
                chk("baseaddr_hold", bus.sdr_baseaddr, cur.addr);
                chk("nelems_hold", 32'(bus.sdr_nelems), 32'(cur.n));
                chk_data("data_hold", bus.sdr_writedata, cur.data);
            end
            if (bus.sdr_writestart === 1'b1) begin
                if (mon_open) begin
                    chk("writestart_width", 32'(bus.sdr_writestart), 32'd0);
                end else if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_writestart: got 1, expected 0 (t=%0t)", $time);
                end else begin
                    cur = exp_q.pop_front();
                    chk("burst_baseaddr", bus.sdr_baseaddr, cur.addr);
                    chk("burst_nelems", 32'(bus.sdr_nelems), 32'(cur.n));
                    chk_data("burst_data", bus.sdr_writedata, cur.data);
                    mon_open = 1'b1;
                end
            end
            if (bus.sdr_writeend === 1'b1) begin
                chk_done_next = 1'b1;
                exp_done_next = mon_open ? cur.last : 1'b0;
                mon_open      = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] wq[$];
        int          total;
        bit          fwl;
        sdr_reset_n   = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = 32'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge sdr_clk);

        // Reset values.
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_writestart", 32'(bus.sdr_writestart), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_nelems", 32'(bus.sdr_nelems), 32'd0);
        chk("rst_baseaddr", bus.sdr_baseaddr, 32'd0);
        chk("rst_data_nonzero", 32'(|bus.sdr_writedata), 32'd0);
        sdr_reset_n = 1'b1;
        tick();

        // Full burst of 0..63 at 0x1000, then an empty flush.
        wq.delete();
        for (int k = 0; k < NWORDS; k++) wq.push_back(32'(k));
        begin_session(32'h0000_1000, wq, 1'b0);
        send_words(wq, 1'b0, 0, 1'b0);
        wait_writeend();
        @(negedge sdr_clk);
        chk("s1_baseaddr_next", bus.sdr_baseaddr, 32'h0000_1100);
        chk("s1_back_in_fill", 32'(bus.in_ready), 32'd1);
        chk("s1_nelems_cleared", 32'(bus.sdr_nelems), 32'd0);
        tick();
        end_session(NWORDS, 1'b0);

        // Five words then a separate flush.
        wq.delete();
        for (int k = 0; k < 5; k++) wq.push_back(32'hA0 + 32'(k));
        begin_session(32'h0000_2000, wq, 1'b0);
        send_words(wq, 1'b0, 1, 1'b0);
        end_session(5, 1'b0);

        // Flush together with the third word.
        wq.delete();
        for (int k = 0; k < 3; k++) wq.push_back(32'hC0DE_0000 + 32'(k));
        begin_session(32'h0000_3000, wq, 1'b1);
        send_words(wq, 1'b1, 0, 1'b0);
        end_session(3, 1'b1);

        // Start then immediate flush: done, no burst.
        wq.delete();
        begin_session(32'h0000_4000, wq, 1'b0);
        end_session(0, 1'b0);
        chk("s4_idle", 32'(bus.busy), 32'd0);

        // Continuous in_valid through slow bursts, address wrap past 2^32.
        bridge_delay = 10;
        wq.delete();
        for (int k = 0; k < NWORDS + 10; k++) wq.push_back($urandom);
        begin_session(32'hFFFF_FF00, wq, 1'b1);
        send_words(wq, 1'b1, 0, 1'b0);
        end_session(NWORDS + 10, 1'b1);
        chk("s6_wrapped_base", bus.sdr_baseaddr, 32'hFFFF_FF00 + 32'(4 * (NWORDS + 10)));
        bridge_delay = 0;

        // Randomized sessions with gaps and ignored start pulses.
        for (int s = 0; s < 6; s++) begin
            logic [31:0] base;
            base  = $urandom;
            total = $urandom_range(0, 140);
            fwl   = (total > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            wq.delete();
            for (int k = 0; k < total; k++) wq.push_back($urandom);
            begin_session(base, wq, fwl);
            send_words(wq, fwl, 2, 1'b1);
            end_session(total, fwl);
            chk("rand_end_base", bus.sdr_baseaddr, base + 32'(4 * total));
        end

        // Reset during WAIT; the late writeend must be ignored.
        bridge_delay = 8;
        wq.delete();
        for (int k = 0; k < 8; k++) wq.push_back(32'h5500 + 32'(k));
        begin_session(32'h0000_8000, wq, 1'b0);
        send_words(wq, 1'b0, 0, 1'b0);
        do_flush();
        begin
            int t = 0;
            @(negedge sdr_clk);
            while ((bus.sdr_writestart !== 1'b1) && (t < 200)) begin
                @(negedge sdr_clk);
                t++;
            end
            if (t >= 200) timeout_fail("s5_writestart");
        end
        @(negedge sdr_clk);
        sdr_reset_n = 1'b0;
        mon_open    = 1'b0;
        @(negedge sdr_clk);
        sdr_reset_n = 1'b1;
        wait_writeend();
        @(negedge sdr_clk);
        chk("s5_busy", 32'(bus.busy), 32'd0);
        chk("s5_in_ready", 32'(bus.in_ready), 32'd0);
        chk("s5_writestart", 32'(bus.sdr_writestart), 32'd0);
        chk("s5_nelems", 32'(bus.sdr_nelems), 32'd0);
        chk("s5_baseaddr", bus.sdr_baseaddr, 32'd0);
        chk("s5_data_nonzero", 32'(|bus.sdr_writedata), 32'd0);
        repeat (4) @(negedge sdr_clk);
        chk("s5_stays_idle", 32'(bus.busy), 32'd0);
        bridge_delay = 0;

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("imm_done_left", 32'(imm_done_cnt), 32'd0);
        chk("burst_left_open", 32'(mon_open), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
